// File: rtl/minmax_sequencer.sv
// Burst min/max finder: one shared signed less-than comparator, two compare
// cycles per sample, first-occurrence indices reported with a one-cycle done.

module comparator_lt #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         lt
);
  assign lt = $signed(a) < $signed(b);
endmodule

// state     | meaning
// S_IDLE    | waiting for start; results hold
// S_FIRST   | accept sample 0, seeds min and max
// S_WAIT    | accept next sample into the sample register
// S_CMP_MIN | comparator: sample < min
// S_CMP_MAX | comparator: max < sample; advance count
// S_DONE    | done pulse, results valid
module minmax_sequencer #(
  parameter int N     = 32,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  output logic             busy,
  output logic             done,
  output logic [N-1:0]     min_out,
  output logic [N-1:0]     max_out,
  output logic [LEN_W-1:0] min_idx,
  output logic [LEN_W-1:0] max_idx
);

  typedef enum logic [2:0] {
    S_IDLE, S_FIRST, S_WAIT, S_CMP_MIN, S_CMP_MAX, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [N-1:0]     sample_q, sample_d;
  logic [LEN_W-1:0] sample_idx_q, sample_idx_d;
  logic [N-1:0]     min_q, min_d, max_q, max_d;
  logic [LEN_W-1:0] min_idx_q, min_idx_d, max_idx_q, max_idx_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [N-1:0] cmp_a, cmp_b;
  logic         cmp_lt;
  logic         hs;

  // Operand order flips between passes so a single lt serves both min and max.
  always_comb begin
    cmp_a = sample_q;
    cmp_b = min_q;
    if (state_q == S_CMP_MAX) begin
      cmp_a = max_q;
      cmp_b = sample_q;
    end
  end

  comparator_lt #(.N(N)) u_cmp (
    .a  (cmp_a),
    .b  (cmp_b),
    .lt (cmp_lt)
  );

  assign hs = in_valid && in_ready_q;

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    count_d      = count_q;
    sample_d     = sample_q;
    sample_idx_d = sample_idx_q;
    min_d        = min_q;
    max_d        = max_q;
    min_idx_d    = min_idx_q;
    max_idx_d    = max_idx_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (len != '0) begin
              len_d   = len;
              count_d = '0;
              state_d = S_FIRST;
            end else begin
              min_d     = '0;
              max_d     = '0;
              min_idx_d = '0;
              max_idx_d = '0;
              state_d   = S_DONE;
            end
          end
        end
        S_FIRST: begin
          if (hs) begin
            min_d     = in_data;
            max_d     = in_data;
            min_idx_d = '0;
            max_idx_d = '0;
            count_d   = LEN_W'(1);
            state_d   = (len_q == LEN_W'(1)) ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (hs) begin
            sample_d     = in_data;
            sample_idx_d = count_q;
            state_d      = S_CMP_MIN;
          end
        end
        S_CMP_MIN: begin
          if (cmp_lt) begin
            min_d     = sample_q;
            min_idx_d = sample_idx_q;
          end
          state_d = S_CMP_MAX;
        end
        S_CMP_MAX: begin
          if (cmp_lt) begin
            max_d     = sample_q;
            max_idx_d = sample_idx_q;
          end
          count_d = count_q + LEN_W'(1);
          state_d = (count_q + LEN_W'(1) == len_q) ? S_DONE : S_WAIT;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Status outputs are decoded from the next state so they align with state_q.
  always_comb begin
    in_ready_d = (state_d == S_FIRST) || (state_d == S_WAIT);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      count_q      <= '0;
      sample_q     <= '0;
      sample_idx_q <= '0;
      min_q        <= '0;
      max_q        <= '0;
      min_idx_q    <= '0;
      max_idx_q    <= '0;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      count_q      <= count_d;
      sample_q     <= sample_d;
      sample_idx_q <= sample_idx_d;
      min_q        <= min_d;
      max_q        <= max_d;
      min_idx_q    <= min_idx_d;
      max_idx_q    <= max_idx_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign min_out  = min_q;
  assign max_out  = max_q;
  assign min_idx  = min_idx_q;
  assign max_idx  = max_idx_q;

endmodule

// File: doc/minmax_sequencer.md
# minmax_sequencer

Sequential controller that time-shares one `comparator_lt` instance (N-bit, signed) to find the minimum and maximum of a burst of signed samples. Accepts a length-prefixed burst over a valid/ready stream, runs two compare cycles per sample (min pass, then max pass), and reports min/max values with their first-occurrence indices. Sits between a sample producer and any consumer needing range statistics. It is the sequencing layer above the comparator datapath, and instantiates `comparator_lt` unchanged.

## Interface
- `N`, 32, sample width; samples are two's-complement signed
- `LEN_W`, 8, width of burst length and index outputs
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  begin burst; sampled only in IDLE
- `len`  in  LEN_W  burst length, latched on accepted `start`
- `abort`  in  1  return to IDLE without `done`; highest priority after reset
- `in_valid`  in  1  producer has sample
- `in_ready`  out  1  block can accept sample
- `in_data`  in  N  signed sample
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse, results valid
- `min_out`, `max_out`  out  N  result values
- `min_idx`, `max_idx`  out  LEN_W  0-based index of first occurrence

## Operation
- States: IDLE, FIRST, WAIT, CMP_MIN, CMP_MAX, DONE.
- IDLE: `start`=1, `len`≠0 → latch len, clear count → FIRST. `start`=1, `len`=0 → DONE with `min_out`/`max_out`/indices cleared to 0. `start` outside IDLE is ignored.
- FIRST: `in_ready`=1. Handshake (`in_valid`&`in_ready`) → min=max=`in_data`, both idx=0, count=1. If len=1 → DONE, else → WAIT.
- WAIT: `in_ready`=1. Handshake → sample reg=`in_data`, sample idx=count → CMP_MIN.
- CMP_MIN: comparator a=sample, b=min. If lt → min=sample, min_idx=sample idx. Next state is CMP_MAX.
- CMP_MAX: comparator a=max, b=sample. If lt → max=sample, max_idx=sample idx. Increment count. If count+1==len → DONE, else → WAIT.
- DONE: `done`=1 for exactly one cycle → IDLE. Results hold until the next accepted `start`.
- Strict less-than applies, so ties keep the earliest index.
- `abort`: any state → IDLE next edge. No `done` pulse. Result registers keep their partial values.
- The comparator is the only magnitude-compare hardware. No behavioural `<` on samples.
- Count and index arithmetic is LEN_W unsigned. len=2^LEN_W−1 is the maximum burst.

## Timing
- Reset (async, `rst_n`=0): state IDLE, `in_ready`=0, `busy`=0, `done`=0, `min_out`=`max_out`=0, `min_idx`=`max_idx`=0, count=0.
- `in_ready` is a registered decode of state: high only in FIRST and WAIT. It never depends combinationally on `in_valid`.
- Throughput: one sample per 3 cycles after the first (WAIT, CMP_MIN, CMP_MAX). First sample takes 1 cycle.
- Latency: last handshake at edge k. For len≥2, `done` is high in the cycle after edge k+2. For len=1, `done` is high in the cycle after edge k.
- Zero-length burst: `start` at edge k → `done` high in the cycle after edge k.
- `in_valid` low in FIRST/WAIT stalls indefinitely with no state change.
- `abort` coinciding with a handshake discards the sample.
- `rst_n` asserted mid-burst clears everything immediately, with no wait for the clock.

## Test plan
- Reset then len=4, data {5, −3, 7, −3} at full rate → `done` after 10 cycles total from first handshake; min=−3 idx 1, max=7 idx 2.
- Signed edges, len=3, data {0x7FFFFFFF, 0x80000000, 0} → min=0x80000000 idx 1, max=0x7FFFFFFF idx 0.
- len=1, data 38273 → min=max=38273, both idx 0. len=0 → `done` one cycle after `start`, outputs 0.
- Backpressure: len=5, random `in_valid` gaps → results match reference model. Check that `in_ready` is only ever high in FIRST/WAIT and that no sample is lost or duplicated.
- `abort` after 2 of 4 samples → no `done`, back to IDLE. A following burst {1, 2} → min=1 idx 0, max=2 idx 1.
- `rst_n` low mid-CMP_MIN → all outputs 0 asynchronously. `start` during `busy` is ignored.
- Random: 100 bursts of random len 1–20 and random data, checked against a scoreboard.
